// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative HI/LO multiply/divide unit with operand forwarding
// Divider datapath and DIV/FIX states are built only when EX_MULDIV_DIV_EN is defined.
module ex_muldiv #(
  parameter int XLEN = 32,
  parameter int NFWD = 2,
  parameter int FSEL = $clog2(NFWD + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           md_op,
  input  logic [FSEL-1:0]      fwd_rs,
  input  logic [FSEL-1:0]      fwd_rt,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [XLEN-1:0]      rs_pipeline,
  input  logic [XLEN-1:0]      rt_pipeline,
  input  logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic [XLEN-1:0]      hi,
  output logic [XLEN-1:0]      lo
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     b_q;
  logic                neg_q;
  logic [XLEN-1:0]     hi_q, lo_q;
  logic                done_q;

  logic [XLEN-1:0]     rs_val, rt_val, rs_mag, rt_mag;
  logic                op_mul, op_div, op_mt, op_signed, rs_neg, rt_neg;
  logic                accept, go_mul, go_div, go_mt, last, mul_wr, fix_wr;
  logic [XLEN:0]       msum;
  logic [2*XLEN-1:0]   mul_next, mul_res;

  always_comb begin
    rs_val = rs_pipeline;
    rt_val = rt_pipeline;
    for (int i = 0; i < NFWD; i++) begin
      if (fwd_rs == FSEL'(i)) rs_val = fwd_data[i*XLEN +: XLEN];
      if (fwd_rt == FSEL'(i)) rt_val = fwd_data[i*XLEN +: XLEN];
    end
  end

  assign op_mul    = (md_op == 3'd1) || (md_op == 3'd2);
  assign op_mt     = (md_op == 3'd5) || (md_op == 3'd6);
  assign op_signed = (md_op == 3'd1) || (md_op == 3'd3);
`ifdef EX_MULDIV_DIV_EN
  assign op_div    = (md_op == 3'd3) || (md_op == 3'd4);
`else
  assign op_div    = 1'b0;
`endif

  assign accept = start && !busy && !flush;
  assign go_mul = accept && op_mul;
  assign go_div = accept && op_div;
  assign go_mt  = accept && op_mt;

  // Both datapaths iterate on magnitudes; the sign is reapplied at the end,
  // which keeps the most-negative operand exact.
  assign rs_neg = op_signed && rs_val[XLEN-1];
  assign rt_neg = op_signed && rt_val[XLEN-1];
  assign rs_mag = rs_neg ? (~rs_val + 1'b1) : rs_val;
  assign rt_mag = rt_neg ? (~rt_val + 1'b1) : rt_val;

  assign msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {msum, acc_q[XLEN-1:1]};
  assign mul_res  = neg_q ? (~mul_next + 1'b1) : mul_next;

`ifdef EX_MULDIV_DIV_EN
  logic                rneg_q, dz_q;
  logic [XLEN:0]       dshift, ddiff;
  logic                qbit;
  logic [2*XLEN-1:0]   div_next;
  logic [XLEN-1:0]     quo_fix, rem_fix;

  // acc_q holds {remainder, dividend/quotient}; one restoring step per cycle.
  assign dshift   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign ddiff    = dshift - {1'b0, b_q};
  assign qbit     = !ddiff[XLEN];
  assign div_next = {(qbit ? ddiff[XLEN-1:0] : dshift[XLEN-1:0]), acc_q[XLEN-2:0], qbit};
  assign quo_fix  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign rem_fix  = rneg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_mul)      state_d = S_MUL;
          else if (go_div) state_d = S_DIV;
        end
        S_MUL:   if (last) state_d = S_IDLE;
`ifdef EX_MULDIV_DIV_EN
        S_DIV:   if (last) state_d = S_FIX;
        S_FIX:   state_d = S_IDLE;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    last   = (cnt_q == CW'(XLEN - 1));
    mul_wr = (state_q == S_MUL) && last && !flush;
`ifdef EX_MULDIV_DIV_EN
    fix_wr = (state_q == S_FIX) && !flush;
`else
    fix_wr = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      b_q    <= '0;
      neg_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
`ifdef EX_MULDIV_DIV_EN
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
`endif
    end else begin
      done_q <= mul_wr || fix_wr;
      if (flush || go_mul || go_div)                    cnt_q <= '0;
      else if (state_q == S_MUL || state_q == S_DIV)    cnt_q <= cnt_q + 1'b1;
      if (go_mul || go_div) begin
        acc_q <= {{XLEN{1'b0}}, rs_mag};
        b_q   <= rt_mag;
        neg_q <= rs_neg ^ rt_neg;
`ifdef EX_MULDIV_DIV_EN
        rneg_q <= rs_neg;
        dz_q   <= (rt_val == '0);
`endif
      end else if (state_q == S_MUL) begin
        acc_q <= mul_next;
`ifdef EX_MULDIV_DIV_EN
      end else if (state_q == S_DIV) begin
        acc_q <= div_next;
`endif
      end
      if (go_mt && md_op == 3'd5) hi_q <= rs_val;
      if (go_mt && md_op == 3'd6) lo_q <= rs_val;
      if (mul_wr) {hi_q, lo_q} <= mul_res;
`ifdef EX_MULDIV_DIV_EN
      // A zero divisor leaves the dividend magnitude in the remainder, so rem_fix is the dividend.
      if (fix_wr) begin
        hi_q <= rem_fix;
        lo_q <= dz_q ? '1 : quo_fix;
      end
`endif
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed scoreboard bench for ex_muldiv (XLEN=32, NFWD=2)
module tb_ex_muldiv;
  localparam int XLEN = 32;
  localparam int NFWD = 2;
  localparam int FSEL = $clog2(NFWD + 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 start = 1'b0;
  logic                 flush = 1'b0;
  logic [2:0]           md_op = 3'd0;
  logic [FSEL-1:0]      fwd_rs = FSEL'(NFWD);
  logic [FSEL-1:0]      fwd_rt = FSEL'(NFWD);
  logic [NFWD*XLEN-1:0] fwd_data = '0;
  logic [XLEN-1:0]      rs_pipeline = '0;
  logic [XLEN-1:0]      rt_pipeline = '0;
  logic                 busy, done;
  logic [XLEN-1:0]      hi, lo;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] m_hilo = '0;

  ex_muldiv #(.XLEN(XLEN), .NFWD(NFWD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_data(fwd_data),
    .rs_pipeline(rs_pipeline), .rt_pipeline(rt_pipeline), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] prev);
    logic signed [63:0] sa, sb;
    logic signed [31:0] qa, qb, qq, qr;
    case (op)
      3'd1: begin
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        return sa * sb;
      end
      3'd2: return {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qa = $signed(a);
        qb = $signed(b);
        qq = qa / qb;
        qr = qa % qb;
        return {qr, qq};
      end
      3'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return prev;
    endcase
  endfunction

  // Drives one start edge; a select below NFWD routes the operand through fwd_data.
  task automatic go(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                    input int frs, input int frt);
    fwd_rs = FSEL'(frs);
    fwd_rt = FSEL'(frt);
    if (frs < NFWD) begin fwd_data[frs*XLEN +: XLEN] = a; rs_pipeline = ~a; end
    else rs_pipeline = a;
    if (frt < NFWD) begin fwd_data[frt*XLEN +: XLEN] = b; rt_pipeline = ~b; end
    else rt_pipeline = b;
    md_op = op;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    md_op = 3'd0;
  endtask

  task automatic wait_done(input string tag, input int lat, input int elapsed);
    int cyc;
    cyc = elapsed;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    if (done) begin
      chk({tag, " busy at done"}, {63'd0, busy}, 64'd0);
      if (exp_q.size() != 0) chk({tag, " hilo"}, {hi, lo}, exp_q.pop_front());
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    chk({tag, " done single"}, {63'd0, done}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input int frs, input int frt);
    m_hilo = model(op, a, b, m_hilo);
    exp_q.push_back(m_hilo);
    go(op, a, b, frs, frt);
    chk({tag, " busy"}, {63'd0, busy}, 64'd1);
    wait_done(tag, lat, 0);
  endtask

  task automatic idle_watch(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk({tag, " quiet"}, 64'(seen), 64'd0);
    chk({tag, " hilo kept"}, {hi, lo}, m_hilo);
  endtask

  initial begin
    logic [31:0] ra, rb;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mult -1*2", 3'd1, 32'hFFFF_FFFF, 32'h2, 32, NFWD, NFWD);
    run_op("multu ff*2", 3'd2, 32'hFFFF_FFFF, 32'h2, 32, NFWD, NFWD);
    run_op("mult min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32, NFWD, NFWD);
    run_op("mult min*-1", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32, NFWD, NFWD);
    run_op("multu fwd", 3'd2, 32'h1234, 32'h5, 32, 0, 1);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op((i % 2) ? "multu rnd" : "mult rnd", (i % 2) ? 3'd2 : 3'd1, ra, rb, 32, NFWD, NFWD);
    end

    // Move-to with forwarding
    fwd_data[XLEN +: XLEN] = 32'd5;
    fwd_data[0 +: XLEN] = 32'h1234;
    rs_pipeline = 32'd9;
    fwd_rs = FSEL'(1); md_op = 3'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    m_hilo[31:0] = 32'd5;
    chk("mtlo fwd1 lo", {32'd0, lo}, 64'd5);
    chk("mtlo busy", {63'd0, busy}, 64'd0);
    chk("mtlo done", {63'd0, done}, 64'd0);
    fwd_rs = FSEL'(NFWD); md_op = 3'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    m_hilo[31:0] = 32'd9;
    chk("mtlo pipe lo", {hi, lo}, m_hilo);
    fwd_rs = FSEL'(0); md_op = 3'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    m_hilo[63:32] = 32'h1234;
    chk("mthi fwd0", {hi, lo}, m_hilo);
    fwd_rs = FSEL'(NFWD + 1); rs_pipeline = 32'hABCD; md_op = 3'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; md_op = 3'd0;
    m_hilo[63:32] = 32'hABCD;
    chk("mthi sel3", {hi, lo}, m_hilo);

    // Start while busy is dropped
    ra = m_hilo[31:0];
    m_hilo = model(3'd2, 32'd3, 32'd4, m_hilo);
    exp_q.push_back(m_hilo);
    go(3'd2, 32'd3, 32'd4, NFWD, NFWD);
    fwd_rs = FSEL'(NFWD); rs_pipeline = 32'hDEAD; md_op = 3'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; md_op = 3'd0;
    chk("busy start lo", {32'd0, lo}, {32'd0, ra});
    wait_done("busy start", 32, 1);

`ifdef EX_MULDIV_DIV_EN
    run_op("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2, 33, NFWD, NFWD);
    run_op("div by 0", 3'd3, 32'hFFFF_FFF9, 32'd0, 33, NFWD, NFWD);
    run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 33, NFWD, NFWD);
    run_op("divu 100/7", 3'd4, 32'd100, 32'd7, 33, NFWD, NFWD);
    run_op("div 100/-7", 3'd3, 32'd100, 32'hFFFF_FFF9, 33, NFWD, NFWD);
    run_op("divu by 0", 3'd4, 32'h8000_0001, 32'd0, 33, NFWD, NFWD);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 70000);
      run_op((i % 2) ? "divu rnd" : "div rnd", (i % 2) ? 3'd4 : 3'd3, ra, rb, 33, NFWD, NFWD);
    end
`else
    go(3'd3, 32'hFFFF_FFF9, 32'd2, NFWD, NFWD);
    chk("div off busy", {63'd0, busy}, 64'd0);
    idle_watch("div off", 40);
    go(3'd4, 32'd100, 32'd7, NFWD, NFWD);
    idle_watch("divu off", 40);
`endif

    // Flush at iteration 10
    go(3'd2, 32'h1111, 32'h2222, NFWD, NFWD);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", {63'd0, busy}, 64'd0);
    chk("flush hilo", {hi, lo}, m_hilo);
    idle_watch("after flush", 40);

    // Flush beats a simultaneous start
    fwd_rs = FSEL'(NFWD); rs_pipeline = 32'h77; md_op = 3'd6; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; md_op = 3'd0;
    chk("flush+start hilo", {hi, lo}, m_hilo);
    chk("flush+start busy", {63'd0, busy}, 64'd0);

    // Reset mid-operation
    go(3'd2, 32'h1111, 32'h2222, NFWD, NFWD);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst mid busy", {63'd0, busy}, 64'd0);
    chk("rst mid done", {63'd0, done}, 64'd0);
    chk("rst mid hilo", {hi, lo}, 64'd0);
    m_hilo = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post-reset mult", 3'd1, 32'd3, 32'hFFFF_FFFE, 32, NFWD, NFWD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
